// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared state type, grant width and round-robin helper for axis_packet_arbiter
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int MAX_PORTS = 16;

    // Width of a port index; a single-port build still needs one bit
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of valid_vec searching upward from last+1, wrapping within n ports.
    // Walking the offsets downward lets the smallest offset win the final assignment.
    function automatic logic [3:0] next_rr(input logic [MAX_PORTS-1:0] valid_vec,
                                           input logic [3:0]           last,
                                           input int                   n);
        logic [3:0] idx;
        int         p;
        idx = '0;
        p   = 0;
        for (int k = MAX_PORTS; k >= 1; k--) begin
            if (k <= n) begin
                p = (int'(last) + k) % n;
                if (valid_vec[p[3:0]]) begin
                    idx = p[3:0];
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// rtl/axis_packet_arbiter_if.sv - bundle of LANES parallel AXI-Stream channels with master/slave views
interface axis_packet_arbiter_if #(
    parameter int LANES       = 1,
    parameter int DATA_WIDTH  = 8,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
);
    logic [LANES-1:0]                   tvalid;
    logic [LANES-1:0]                   tready;
    logic [LANES-1:0][DATA_WIDTH-1:0]   tdata;
    logic [LANES-1:0][DATA_WIDTH/8-1:0] tkeep;
    logic [LANES-1:0]                   tlast;
    logic [LANES-1:0][TID_WIDTH-1:0]    tid;
    logic [LANES-1:0][TDEST_WIDTH-1:0]  tdest;
    logic [LANES-1:0][TUSER_WIDTH-1:0]  tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_rr_pick.sv
// rtl/axis_rr_pick.sv - combinational rotating-priority picker over a request vector
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int GRANT_W   = grant_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_valid,
    input  logic [GRANT_W-1:0]   i_last,
    output logic [GRANT_W-1:0]   o_idx,
    output logic                 o_any_valid
);
    logic [MAX_PORTS-1:0] w_valid_ext;
    logic [3:0]           w_last_ext;
    logic [3:0]           w_idx;

    assign w_valid_ext = MAX_PORTS'(i_valid);
    assign w_last_ext  = 4'(i_last);
    assign w_idx       = next_rr(w_valid_ext, w_last_ext, NUM_PORTS);
    assign o_idx       = GRANT_W'(w_idx);
    assign o_any_valid = |i_valid;
endmodule

// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - packet-level round-robin AXI-Stream arbiter with registered output; AXIS_ARB_TID_EN puts the port index on m_axis tid
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_PORTS   = 4,
    parameter  int DATA_WIDTH  = 8,
    parameter  int TID_WIDTH   = 1,
    parameter  int TDEST_WIDTH = 1,
    parameter  int TUSER_WIDTH = 1,
    localparam int GRANT_W     = grant_w(NUM_PORTS)
) (
    input  logic                  aclk,
    input  logic                  areset,
    axis_packet_arbiter_if.slave  s_axis,
    axis_packet_arbiter_if.master m_axis,
    output logic [GRANT_W-1:0]    grant_idx
);
    localparam int KEEP_W = DATA_WIDTH / 8;
`ifdef AXIS_ARB_TID_EN
    localparam int M_TID_W = GRANT_W;
`else
    localparam int M_TID_W = TID_WIDTH;
`endif
    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_BUSY = ST_BUSY;

    logic [0:0]             r_state;
    logic [GRANT_W-1:0]     r_grant;
    logic [GRANT_W-1:0]     r_last_grant;
    logic                   r_m_tvalid;
    logic [DATA_WIDTH-1:0]  r_m_tdata;
    logic [KEEP_W-1:0]      r_m_tkeep;
    logic                   r_m_tlast;
    logic [M_TID_W-1:0]     r_m_tid;
    logic [TDEST_WIDTH-1:0] r_m_tdest;
    logic [TUSER_WIDTH-1:0] r_m_tuser;

    logic [GRANT_W-1:0]     w_pick_idx;
    logic                   w_any_valid;
    logic                   w_m_free;
    logic                   w_s_ready;
    logic                   w_accept;
    logic [NUM_PORTS-1:0]   w_tready_vec;

    axis_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .i_valid     (s_axis.tvalid),
        .i_last      (r_last_grant),
        .o_idx       (w_pick_idx),
        .o_any_valid (w_any_valid)
    );

    // The output register can take a beat when it is empty or being drained this cycle
    assign w_m_free  = !r_m_tvalid || m_axis.tready[0];
    assign w_s_ready = (r_state == S_BUSY) && w_m_free;
    assign w_accept  = w_s_ready && s_axis.tvalid[r_grant];

    // Ready goes only to the granted port; everyone else waits
    always_comb begin
        w_tready_vec = '0;
        if (w_s_ready) begin
            w_tready_vec[r_grant] = 1'b1;
        end
    end

    // Arbitrate in IDLE, hold the grant until the tlast beat is accepted
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= GRANT_W'(NUM_PORTS - 1);
        end else if (r_state == S_IDLE) begin
            if (w_any_valid) begin
                r_grant      <= w_pick_idx;
                r_last_grant <= w_pick_idx;
                r_state      <= S_BUSY;
            end
        end else begin
            if (w_accept && s_axis.tlast[r_grant]) begin
                r_state <= S_IDLE;
            end
        end
    end

    // Output register: load accepted beats, drop valid once drained with nothing new
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tid    <= '0;
            r_m_tdest  <= '0;
            r_m_tuser  <= '0;
        end else if (w_m_free) begin
            r_m_tvalid <= w_accept;
            if (w_accept) begin
                r_m_tdata <= s_axis.tdata[r_grant];
                r_m_tkeep <= s_axis.tkeep[r_grant];
                r_m_tlast <= s_axis.tlast[r_grant];
`ifdef AXIS_ARB_TID_EN
                r_m_tid   <= r_grant;
`else
                r_m_tid   <= s_axis.tid[r_grant];
`endif
                r_m_tdest <= s_axis.tdest[r_grant];
                r_m_tuser <= s_axis.tuser[r_grant];
            end
        end
    end

    assign s_axis.tready    = w_tready_vec;
    assign m_axis.tvalid[0] = r_m_tvalid;
    assign m_axis.tdata[0]  = r_m_tdata;
    assign m_axis.tkeep[0]  = r_m_tkeep;
    assign m_axis.tlast[0]  = r_m_tlast;
    assign m_axis.tid[0]    = r_m_tid;
    assign m_axis.tdest[0]  = r_m_tdest;
    assign m_axis.tuser[0]  = r_m_tuser;
    assign grant_idx        = r_grant;
endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream datapath (typically the data-width converter input) between NUM_PORTS upstream requesters. It grants one slave port at a time, holds the grant for the whole packet (until an accepted beat with tlast), then re-arbitrates. The output side is fully registered, so the block sits directly in front of the converter with no combinational path from m_axis_tready to any s_axis_tvalid.

## Interface
- NUM_PORTS, 4, number of requesting slave streams (2..16)
- DATA_WIDTH, 8, tdata width in bits (multiple of 8); tkeep is DATA_WIDTH/8
- TID_WIDTH, 1, per-port tid width
- TDEST_WIDTH, 1, tdest width
- TUSER_WIDTH, 1, tuser width

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  reset, synchronous and active-high
- s_axis_tvalid  in  [NUM_PORTS-1:0]  per-port valid
- s_axis_tready  out  [NUM_PORTS-1:0]  per-port ready; at most one bit high
- s_axis_tdata  in  [NUM_PORTS-1:0][DATA_WIDTH-1:0]  per-port data
- s_axis_tkeep  in  [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]  per-port keep
- s_axis_tlast  in  [NUM_PORTS-1:0]  per-port end of packet
- s_axis_tid  in  [NUM_PORTS-1:0][TID_WIDTH-1:0]  per-port id
- s_axis_tdest  in  [NUM_PORTS-1:0][TDEST_WIDTH-1:0]  per-port dest
- s_axis_tuser  in  [NUM_PORTS-1:0][TUSER_WIDTH-1:0]  per-port user
- m_axis_tvalid/tready/tdata/tkeep/tlast/tdest/tuser  out/in/out...  single-port equivalents of the above
- m_axis_tid  out  TID_WIDTH, or $clog2(NUM_PORTS) with AXIS_ARB_TID_EN  output id
- grant_idx  out  $clog2(NUM_PORTS)  currently/last granted port (debug)

## Operation
- States: IDLE, BUSY.
- IDLE: all s_axis_tready low. If any s_axis_tvalid is high, choose the first valid port searching upward from last_grant+1 (wrapping), register it into grant_idx and last_grant, go to BUSY. If none is valid, stay.
- BUSY: s_axis_tready[grant_idx] = !m_axis_tvalid || m_axis_tready; other bits 0. An accepted beat loads the output register. An accepted beat with tlast → IDLE.
- Output register: loads when (!m_axis_tvalid || m_axis_tready). m_axis_tvalid clears when m_axis_tready is high and no new beat is accepted.
- Packets are never interleaved. Requests on non-granted ports wait; their tvalid may stay high indefinitely.
- A valid dropped by the granted port mid-packet (a protocol violation upstream) leaves BUSY held. No timeout.
- Reset: state IDLE, last_grant = NUM_PORTS-1 (port 0 has first priority), grant_idx 0. All outputs 0: m_axis_tvalid, tdata, tkeep, tlast, tid, tdest, tuser, s_axis_tready. Reset mid-packet drops the in-flight beat and packet with no recovery.

## Timing
- Cycle 0: a valid is seen in IDLE. Cycle 1: BUSY, ready asserted, first beat accepted at the end of cycle 1. Cycle 2: m_axis_tvalid high.
- Latency from slave acceptance to master valid: 1 cycle.
- Within a packet: 1 beat/cycle under continuous m_axis_tready.
- Between packets: exactly 1 dead cycle on the slave side (the IDLE arbitration cycle). Master-side bubble is 1 cycle.
- Simultaneous tlast acceptance and new requests: the new arbitration happens in the following IDLE cycle using the updated last_grant.
- Output payload is stable while m_axis_tvalid && !m_axis_tready.

## Configuration
- AXIS_ARB_TID_EN defined: m_axis_tid is $clog2(NUM_PORTS) wide and carries the granted port index, registered with the beat. s_axis_tid is ignored.
- Undefined: m_axis_tid is TID_WIDTH wide and carries the granted port's s_axis_tid.

## Structure
- Package axis_arb_pkg holds:
  - state enum (IDLE, BUSY)
  - GRANT_W localparam function ($clog2 with a minimum of 1)
  - a next_rr(valid_vec, last) function prototype
- Sub-module axis_rr_pick: combinational rotating-priority picker. Inputs: valid vector and last grant. Outputs: index and any_valid.

## Test plan
- Only port 1 valid, 3-beat packet 0xA1,0xA2,0xA3 (tlast on third) → m_axis emits the same 3 beats with tlast on 0xA3; only s_axis_tready[1] ever asserts; first m_axis_tvalid 2 cycles after port 1 tvalid rises.
- Ports 0–3 all continuously valid with 2-beat packets → grant order 0,1,2,3,0,1; one idle slave cycle between packets.
- m_axis_tready low for 5 cycles mid-packet → m_axis_tdata/tkeep/tlast held constant, s_axis_tready low, no beat lost or duplicated.
- Port 0 sending an 8-beat packet; port 2 raises single-beat valid at beat 3 → port 0 beats 4–8 complete before port 2's beat appears; no interleave.
- areset asserted on beat 2 of a 4-beat packet → next cycle all outputs 0, state IDLE; after release with ports 0 and 3 valid, port 0 is granted first.
- AXIS_ARB_TID_EN defined, port 3 sends a packet with s_axis_tid=0 → m_axis_tid=3 on every beat; with the macro undefined → m_axis_tid=0.
